issue_rename: RTL and testbench

ISSUE_RENAME -- requirements
Module: issue_rename

---
 rtl/issue_rename.sv | 158 +++++++++++++++
 tb/tb_issue_rename.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_rename.sv
// Rename/issue stage: decodes one instruction per cycle, allocates a ROB entry and
// RS slot, resolves operands through the rename table and retires from the ROB head.
module issue_rename #(
  parameter  int DATA_W    = 16,
  parameter  int NREG      = 16,
  parameter  int ROB_DEPTH = 8,
  parameter  int RS_N      = 3,
  localparam int REG_W     = $clog2(NREG),
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  output logic [1:0]        out_class,
  output logic [3:0]        out_func,
  output logic [REG_W-1:0]  out_rd,
  output logic [TAG_W-1:0]  out_rob,
  output logic              out_rs1_rdy,
  output logic              out_rs2_rdy,
  output logic [DATA_W-1:0] out_rs1_val,
  output logic [DATA_W-1:0] out_rs2_val,
  input  logic [2:0]        rs_free,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              commit_valid,
  input  logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  head_tag,
  output logic [TAG_W:0]    rob_count,
  output logic              illegal
);
  localparam int OCC_W = $clog2(RS_N + 1);
  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_BR  = 2'd2;

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q;
  logic [REG_W-1:0]  rob_rd_q  [ROB_DEPTH];
  logic [1:0]        rob_cls_q [ROB_DEPTH];
  logic [NREG-1:0]   busy_q;
  logic [TAG_W-1:0]  tag_q     [NREG];
  logic [DATA_W-1:0] regfile_q [NREG];

  logic              out_valid_q, illegal_q, rs1_rdy_q, rs2_rdy_q;
  logic [1:0]        class_q;
  logic [3:0]        func_q;
  logic [REG_W-1:0]  rd_q;
  logic [TAG_W-1:0]  rob_q;
  logic [DATA_W-1:0] rs1_val_q, rs2_val_q;

  logic              is_illegal, accept, issue, commit_fire, head_is_br;
  logic [1:0]        in_class;
  logic [2:0]        rs_room;
  logic [REG_W-1:0]  head_rd;
  logic [REG_W-1:0]  src [2];
  logic [DATA_W:0]   opnd [2];

  assign is_illegal  = in_func[3];
  assign in_class    = in_func[2] ? CLS_BR : (in_func[1] ? CLS_MUL : CLS_ADD);
  assign in_ready    = (count_q < (TAG_W+1)'(ROB_DEPTH)) &
                       (is_illegal | (in_func[2] ? rs_room[2] : (in_func[1] ? rs_room[1] : rs_room[0])));
  assign accept      = in_valid & in_ready;
  assign issue       = accept & ~is_illegal;
  assign commit_fire = commit_valid & (count_q != '0);
  assign head_rd     = rob_rd_q[head_q];
  assign head_is_br  = (rob_cls_q[head_q] == CLS_BR);

  // Returns {rdy, value}: committing head beats the CDB; otherwise forward the tag.
  function automatic logic [DATA_W:0] resolve(input logic busy, input logic [TAG_W-1:0] tag,
                                              input logic [DATA_W-1:0] rf_val);
    if (!busy)                                return {1'b1, rf_val};
    else if (commit_fire && tag == head_q)    return {1'b1, commit_data};
    else if (cdb_valid && tag == cdb_tag)     return {1'b1, cdb_data};
    else                                      return {1'b0, DATA_W'(tag)};
  endfunction

  assign src[0] = in_rs1;
  assign src[1] = in_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign opnd[gi] = resolve(busy_q[src[gi]], tag_q[src[gi]], regfile_q[src[gi]]);
    end

    for (gi = 0; gi < 3; gi++) begin : g_occ
      logic [OCC_W-1:0] occ_q;
      logic             inc, dec;
      assign inc         = issue && (in_class == 2'(gi));
      assign dec         = rs_free[gi] && (occ_q != '0);
      assign rs_room[gi] = (occ_q < OCC_W'(RS_N));
      always_ff @(posedge clk1) begin
        if (rst)              occ_q <= '0;
        else if (inc && !dec) occ_q <= occ_q + OCC_W'(1);
        else if (dec && !inc) occ_q <= occ_q - OCC_W'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk1) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regfile_q[i] <= '0;
    end else begin
      out_valid_q <= issue;
      illegal_q   <= accept & is_illegal;
      count_q     <= count_q + (TAG_W+1)'(issue) - (TAG_W+1)'(commit_fire);
      if (commit_fire) begin
        head_q <= head_q + TAG_W'(1);
        if (!head_is_br) begin
          regfile_q[head_rd] <= commit_data;
          if (tag_q[head_rd] == head_q) busy_q[head_rd] <= 1'b0;
        end
      end
      // Placed after the commit clear so a same-cycle remap of the same rd wins.
      if (issue) begin
        rob_rd_q[tail_q]  <= in_rd;
        rob_cls_q[tail_q] <= in_class;
        tail_q            <= tail_q + TAG_W'(1);
        class_q           <= in_class;
        func_q            <= in_func;
        rd_q              <= in_rd;
        rob_q             <= tail_q;
        {rs1_rdy_q, rs1_val_q} <= opnd[0];
        {rs2_rdy_q, rs2_val_q} <= opnd[1];
        if (in_class != CLS_BR) begin
          busy_q[in_rd] <= 1'b1;
          tag_q[in_rd]  <= tail_q;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_class   = class_q;
  assign out_func    = func_q;
  assign out_rd      = rd_q;
  assign out_rob     = rob_q;
  assign out_rs1_rdy = rs1_rdy_q;
  assign out_rs2_rdy = rs2_rdy_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign head_tag    = head_q;
  assign rob_count   = count_q;
  assign illegal     = illegal_q;
endmodule

// File: tb/tb_issue_rename.sv
// Bench for issue_rename: directed vector table, corner-case sequences and random
// traffic, all compared against a queue-based reference model of the rename stage.
module tb_issue_rename;
  localparam int DATA_W = 16, NREG = 16, ROB_DEPTH = 8, RS_N = 3;
  localparam int REG_W = 4, TAG_W = 3;

  logic              clk1 = 1'b0;
  logic              rst, in_valid, in_ready;
  logic [3:0]        in_func;
  logic [REG_W-1:0]  in_rs1, in_rs2, in_rd;
  logic              out_valid, out_rs1_rdy, out_rs2_rdy, illegal;
  logic [1:0]        out_class;
  logic [3:0]        out_func;
  logic [REG_W-1:0]  out_rd;
  logic [TAG_W-1:0]  out_rob, cdb_tag, head_tag;
  logic [DATA_W-1:0] out_rs1_val, out_rs2_val, cdb_data, commit_data;
  logic [2:0]        rs_free;
  logic              cdb_valid, commit_valid;
  logic [TAG_W:0]    rob_count;

  issue_rename #(.DATA_W(DATA_W), .NREG(NREG), .ROB_DEPTH(ROB_DEPTH), .RS_N(RS_N)) dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .out_valid(out_valid),
    .out_class(out_class), .out_func(out_func), .out_rd(out_rd), .out_rob(out_rob),
    .out_rs1_rdy(out_rs1_rdy), .out_rs2_rdy(out_rs2_rdy), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .rs_free(rs_free), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .commit_valid(commit_valid), .commit_data(commit_data),
    .head_tag(head_tag), .rob_count(rob_count), .illegal(illegal));

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: ROB as a queue of {rd, class}, tags are ROB slot numbers.
  typedef struct { int rd; int cls; } ent_t;
  ent_t m_rob[$];
  int   m_reg [NREG];
  bit   m_busy[NREG];
  int   m_tag [NREG];
  int   m_occ [3];
  int   m_head;
  bit   m_known = 1'b0;

  task automatic m_clear();
    m_rob.delete();
    m_head = 0;
    for (int i = 0; i < NREG; i++) begin m_reg[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    for (int c = 0; c < 3; c++) m_occ[c] = 0;
    m_known = 1'b1;
  endtask

  function automatic void m_resolve(input int r, input bit cfire, output bit rdy, output int val);
    rdy = 1'b1;
    val = m_reg[r];
    if (m_busy[r]) begin
      if (cfire && m_tag[r] == m_head)                 val = int'(commit_data);
      else if (cdb_valid && m_tag[r] == int'(cdb_tag)) val = int'(cdb_data);
      else begin rdy = 1'b0; val = m_tag[r]; end
    end
  endfunction

  // One clock: check in_ready on current inputs, advance model, check outputs after the edge.
  task automatic step();
    bit ill, rdy, acc, cfire, e_valid, e_ill, r1r, r2r;
    bit dec [3];
    int cls, sz, tail, r1v, r2v, e_cls, e_func, e_rd;
    ent_t e;
    #1;
    ill = (in_func >= 8);
    cls = ill ? 0 : (in_func >= 4 ? 2 : int'(in_func) / 2);
    sz  = m_rob.size();
    rdy = (sz < ROB_DEPTH) && (ill || m_occ[cls] < RS_N);
    if (m_known) chk("in_ready", in_ready, rdy);
    acc     = in_valid && rdy && !rst;
    cfire   = commit_valid && sz > 0;
    tail    = (m_head + sz) % ROB_DEPTH;
    e_valid = acc && !ill;
    e_ill   = acc && ill;
    e_cls = cls; e_func = int'(in_func); e_rd = int'(in_rd);
    m_resolve(int'(in_rs1), cfire, r1r, r1v);
    m_resolve(int'(in_rs2), cfire, r2r, r2v);
    if (rst) m_clear();
    else if (m_known) begin
      for (int c = 0; c < 3; c++) dec[c] = rs_free[c] && m_occ[c] > 0;
      if (cfire) begin
        e = m_rob.pop_front();
        if (e.cls != 2) begin
          m_reg[e.rd] = int'(commit_data);
          if (m_busy[e.rd] && m_tag[e.rd] == m_head) m_busy[e.rd] = 1'b0;
        end
        m_head = (m_head + 1) % ROB_DEPTH;
      end
      if (e_valid) begin
        e.rd = e_rd; e.cls = cls;
        m_rob.push_back(e);
        if (cls != 2) begin m_busy[e_rd] = 1'b1; m_tag[e_rd] = tail; end
        m_occ[cls]++;
      end
      for (int c = 0; c < 3; c++) if (dec[c]) m_occ[c]--;
    end
    @(posedge clk1);
    #1;
    if (m_known) begin
      chk("out_valid", out_valid, e_valid);
      chk("illegal", illegal, e_ill);
      chk("rob_count", rob_count, m_rob.size());
      chk("head_tag", head_tag, m_head);
      if (e_valid) begin
        chk("out_class", out_class, e_cls);
        chk("out_func", out_func, e_func);
        chk("out_rd", out_rd, e_rd);
        chk("out_rob", out_rob, tail);
        chk("rs1_rdy", out_rs1_rdy, r1r);
        chk("rs1_val", out_rs1_val, r1v);
        chk("rs2_rdy", out_rs2_rdy, r2r);
        chk("rs2_val", out_rs2_val, r2v);
      end
    end
  endtask

  task automatic set_idle();
    rst = 0; in_valid = 0; in_func = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    rs_free = '0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0; commit_valid = 0; commit_data = '0;
  endtask

  task automatic issue(input int f, input int r1, input int r2, input int rd);
    in_valid = 1; in_func = 4'(f); in_rs1 = REG_W'(r1); in_rs2 = REG_W'(r2); in_rd = REG_W'(rd);
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; step(); rst = 0;
  endtask

  typedef struct {
    int func, rs1, rs2, rd, cdb_v, cdb_tag, cdb_data, cmt_v, cmt_data;
    int rob, r1rdy, r1val, r2rdy, r2val;
  } vec_t;
  vec_t vt [8];

  initial begin
    vt[0] = '{0, 1, 2, 3, 0, 0, 0,      0, 0,      0, 1, 0,      1, 0};
    vt[1] = '{2, 3, 3, 4, 0, 0, 0,      0, 0,      1, 0, 0,      0, 0};
    vt[2] = '{3, 3, 3, 5, 1, 0, 'h55,   0, 0,      2, 1, 'h55,   1, 'h55};
    vt[3] = '{4, 4, 5, 0, 0, 0, 0,      0, 0,      3, 0, 1,      0, 2};
    vt[4] = '{1, 0, 4, 6, 1, 1, 'hBEEF, 0, 0,      4, 1, 0,      1, 'hBEEF};
    vt[5] = '{0, 3, 3, 3, 0, 0, 0,      0, 0,      5, 0, 0,      0, 0};
    vt[6] = '{2, 3, 6, 8, 0, 0, 0,      1, 'h777,  6, 0, 5,      0, 4};
    vt[7] = '{5, 3, 1, 9, 0, 0, 0,      1, 'hAAA,  7, 0, 5,      1, 0};

    set_idle();
    do_reset();
    chk("reset_ready", in_ready, 1);
    chk("reset_count", rob_count, 0);

    for (int i = 0; i < 8; i++) begin
      set_idle();
      issue(vt[i].func, vt[i].rs1, vt[i].rs2, vt[i].rd);
      cdb_valid = (vt[i].cdb_v != 0); cdb_tag = TAG_W'(vt[i].cdb_tag); cdb_data = DATA_W'(vt[i].cdb_data);
      commit_valid = (vt[i].cmt_v != 0); commit_data = DATA_W'(vt[i].cmt_data);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_rob", i), out_rob, vt[i].rob);
      chk($sformatf("vec%0d_r1rdy", i), out_rs1_rdy, vt[i].r1rdy);
      chk($sformatf("vec%0d_r1val", i), out_rs1_val, vt[i].r1val);
      chk($sformatf("vec%0d_r2rdy", i), out_rs2_rdy, vt[i].r2rdy);
      chk($sformatf("vec%0d_r2val", i), out_rs2_val, vt[i].r2val);
    end

    // RS full after three adds; rs_free reopens only from the next cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin set_idle(); issue(0, 1, 2, i + 1); step(); end
    chk("rs_full_ready", in_ready, 0);
    step();
    chk("rs_full_no_issue", out_valid, 0);
    rs_free = 3'b001; step();
    chk("rs_free_same_cycle", out_valid, 0);
    rs_free = 3'b000;
    chk("rs_free_ready", in_ready, 1);
    step();
    chk("rs_free_issue", out_valid, 1);

    // ROB full with eight branches, then commit and wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin set_idle(); issue(4, 0, 0, 0); rs_free = 3'b100; step(); end
    chk("rob_full_count", rob_count, 8);
    chk("rob_full_ready", in_ready, 0);
    set_idle(); commit_valid = 1; rs_free = 3'b100; step();
    chk("commit_head", head_tag, 1);
    chk("commit_count", rob_count, 7);
    set_idle(); issue(4, 0, 0, 0); step();
    chk("wrap_rob", out_rob, 0);

    // Stale commit must not clear a newer mapping.
    do_reset();
    set_idle(); issue(0, 0, 0, 5); step();
    set_idle(); issue(0, 0, 0, 5); step();
    set_idle(); commit_valid = 1; commit_data = 16'h1234; step();
    set_idle(); issue(0, 5, 5, 6); step();
    chk("stale_rdy", out_rs1_rdy, 0);
    chk("stale_val", out_rs1_val, 1);
    set_idle(); commit_valid = 1; commit_data = 16'h4321; rs_free = 3'b001; step();
    set_idle(); issue(0, 5, 0, 7); step();
    chk("commit_rf_rdy", out_rs1_rdy, 1);
    chk("commit_rf_val", out_rs1_val, 16'h4321);

    // Illegal opcode, then reset with five entries in flight.
    do_reset();
    set_idle(); issue(4'b1010, 0, 0, 1); step();
    chk("illegal_pulse", illegal, 1);
    chk("illegal_no_valid", out_valid, 0);
    chk("illegal_count", rob_count, 0);
    for (int i = 0; i < 5; i++) begin
      set_idle(); issue((i % 2) * 2, 0, 0, i + 1); rs_free = 3'b011; step();
    end
    chk("pre_rst_count", rob_count, 5);
    set_idle(); issue(0, 1, 2, 3); rst = 1; step();
    chk("rst_count", rob_count, 0);
    chk("rst_valid", out_valid, 0);
    set_idle(); issue(0, 1, 2, 3); step();
    chk("rst_busy1", out_rs1_rdy, 1);
    chk("rst_busy2", out_rs2_rdy, 1);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int sel;
      set_idle();
      sel = $urandom_range(0, 9);
      in_valid = ($urandom_range(0, 9) < 7);
      in_func = (sel == 9) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      in_rs1 = REG_W'($urandom); in_rs2 = REG_W'($urandom); in_rd = REG_W'($urandom);
      rs_free = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
      cdb_valid = $urandom_range(0, 1) == 1; cdb_tag = TAG_W'($urandom); cdb_data = DATA_W'($urandom);
      commit_valid = $urandom_range(0, 2) == 0; commit_data = DATA_W'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
